imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 183 ++++++++++++++++++
 tb/tb_imem_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed, XOR-checked byte stream and writes 32-bit words into instruction memory.
// Latency: each write strobe comes one cycle after the word's fourth byte; done/error follow the checksum byte by one cycle.
// Backpressure: rx_ready is high through LEN/DATA/CSUM, including write cycles, so the loader never stalls a load mid-stream.
module imem_loader #(
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic                     we,
  output logic [$clog2(DEPTH)-1:0] waddr,
  output logic [31:0]              wdata,
  output logic                     cpu_hold,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int AW   = $clog2(DEPTH);
  // Idle-cycle counter only needs to reach TIMEOUT-1; the cycle that would reach TIMEOUT is the one that fires.
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TLIM_V    = TW'(TLIM);
  localparam logic [31:0]   DEPTH_V   = DEPTH;
  localparam logic [AW-1:0] LAST_FULL = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [AW-1:0]   word_cnt_q;   // index of the word being assembled
  logic [AW-1:0]   last_idx_q;   // index of the final word of this load (N-1)
  logic [1:0]      lane_q;       // byte lane of the next data byte
  logic [23:0]     asm_q;        // first three bytes of the current word
  logic [7:0]      csum_q;       // running XOR of length byte and data bytes
  logic [TW-1:0]   tmo_q;        // consecutive cycles without a transfer

  logic            in_load;
  logic            xfer;
  logic            start_load;
  logic            tmo_hit;
  logic            len_zero;
  logic            len_too_long;
  logic [AW-1:0]   len_last_idx;
  logic            word_done;
  logic            last_word;

  // Handshake and decode helpers shared by the FSM and the datapath.
  assign in_load    = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
  assign rx_ready   = in_load;
  assign busy       = in_load;
  assign xfer       = rx_valid && in_load;
  assign start_load = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));

  // A length byte of zero means a full-memory load.
  assign len_zero     = (rx_data == 8'd0);
  assign len_too_long = ({24'd0, rx_data} > DEPTH_V);
  assign len_last_idx = len_zero ? LAST_FULL : AW'(rx_data - 8'd1);

  assign word_done  = (state_q == DATA) && xfer && (lane_q == 2'd3);
  assign last_word  = (word_cnt_q == last_idx_q);

  // The timeout fires on the TIMEOUT-th consecutive idle cycle; disabled when TIMEOUT is 0.
  assign tmo_hit    = (TIMEOUT > 0) && in_load && !xfer && (tmo_q == TLIM_V);

  // State register; reset drops the loader back to IDLE immediately, abandoning any load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection and state-decoded status outputs.
  always_comb begin
    state_d  = state_q;
    cpu_hold = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LEN;
      end
      LEN: begin
        cpu_hold = 1'b1;
        if (xfer)         state_d = len_too_long ? ERR : DATA;
        else if (tmo_hit) state_d = ERR;
      end
      DATA: begin
        cpu_hold = 1'b1;
        // Leave for CSUM on the last word's fourth byte so the write cycle already sits in CSUM.
        if (word_done && last_word) state_d = CSUM;
        else if (tmo_hit)           state_d = ERR;
      end
      CSUM: begin
        cpu_hold = 1'b1;
        if (xfer)         state_d = (rx_data == csum_q) ? DONE : ERR;
        else if (tmo_hit) state_d = ERR;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_d = LEN;
      end
      ERR: begin
        error    = 1'b1;
        cpu_hold = 1'b1;
        if (start) state_d = LEN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Word assembly, checksum, idle counter and the registered memory write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt_q <= '0;
      last_idx_q <= '0;
      lane_q     <= 2'd0;
      asm_q      <= 24'd0;
      csum_q     <= 8'd0;
      tmo_q      <= '0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= 32'd0;
    end else begin
      we <= 1'b0;
      if (start_load) begin
        word_cnt_q <= '0;
        last_idx_q <= '0;
        lane_q     <= 2'd0;
        asm_q      <= 24'd0;
        csum_q     <= 8'd0;
        tmo_q      <= '0;
      end else if (in_load) begin
        if (xfer) begin
          tmo_q <= '0;
        end else if (tmo_q != TLIM_V) begin
          tmo_q <= tmo_q + 1'b1;
        end

        if (xfer && (state_q == LEN)) begin
          csum_q     <= rx_data;
          last_idx_q <= len_last_idx;
        end

        if (xfer && (state_q == DATA)) begin
          csum_q <= csum_q ^ rx_data;
          if (lane_q == 2'd3) begin
            // Fourth byte completes the word: strobe it out next cycle, little-endian.
            we         <= 1'b1;
            waddr      <= word_cnt_q;
            wdata      <= {rx_data, asm_q};
            word_cnt_q <= word_cnt_q + 1'b1;
            lane_q     <= 2'd0;
          end else begin
            case (lane_q)
              2'd0:    asm_q[7:0]   <= rx_data;
              2'd1:    asm_q[15:8]  <= rx_data;
              default: asm_q[23:16] <= rx_data;
            endcase
            lane_q <= lane_q + 2'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for the instruction-memory loader (DEPTH 64, TIMEOUT 8).
// Latency: checks write strobes one cycle after each fourth byte and status one cycle after the checksum.
// Backpressure: drives bytes back-to-back or with bounded random gaps; every wait on rx_ready is cycle-bounded.
module tb_imem_loader;

  localparam int DEPTH   = 64;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        we;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  // Every write strobe seen on the memory port, in order.
  logic [5:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] ref_q[$];
  logic [31:0] words[$];

  imem_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  // Capture writes on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      wa_q.push_back(waddr);
      wd_q.push_back(wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic gap(input int max_gap);
    if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offers one byte and returns #1 after the edge that transferred it.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok       = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    chk("byte_accepted", 32'(ok), 32'd1);
  endtask

  // Sends length, data (little-endian) and checksum XOR csum_flip; raises start with byte number start_at.
  task automatic send_load(input logic [7:0] len, input logic [31:0] w[$], input int max_gap,
                           input int start_at, input logic [7:0] csum_flip);
    logic [7:0] cs;
    logic [7:0] b;
    int         k;
    cs = len;
    k  = 0;
    send_byte(len);
    gap(max_gap);
    foreach (w[i]) begin
      for (int j = 0; j < 4; j++) begin
        b  = w[i][8*j +: 8];
        cs = cs ^ b;
        if (k == start_at) start = 1'b1;
        send_byte(b);
        start = 1'b0;
        k++;
        gap(max_gap);
      end
    end
    send_byte(cs ^ csum_flip);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) tick();

    // Values held while reset is asserted.
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_we",       32'(we),       32'd0);
    chk("rst_waddr",    32'(waddr),    32'd0);
    chk("rst_wdata",    wdata,         32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_error",    32'(error),    32'd0);
    reset = 1'b0;
    tick();

    // Two-word load, byte by byte; checksum 02^93^02^50^00^13^00^00^00 = D0.
    wa_q.delete(); wd_q.delete();
    pulse_start();
    chk("t1_busy",     32'(busy),     32'd1);
    chk("t1_rx_ready", 32'(rx_ready), 32'd1);
    chk("t1_hold",     32'(cpu_hold), 32'd1);
    send_byte(8'h02);
    send_byte(8'h93); send_byte(8'h02); send_byte(8'h50); send_byte(8'h00);
    chk("t1_we0",      32'(we),    32'd1);
    chk("t1_waddr0",   32'(waddr), 32'd0);
    chk("t1_wdata0",   wdata,      32'h0050_0293);
    send_byte(8'h13);
    chk("t1_we_pulse", 32'(we),    32'd0);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    chk("t1_we1",      32'(we),    32'd1);
    chk("t1_waddr1",   32'(waddr), 32'd1);
    chk("t1_wdata1",   wdata,      32'h0000_0013);
    chk("t1_csum_busy",32'(busy),  32'd1);
    send_byte(8'hD0);
    chk("t1_done",     32'(done),     32'd1);
    chk("t1_error",    32'(error),    32'd0);
    chk("t1_hold_off", 32'(cpu_hold), 32'd0);
    chk("t1_idle",     32'(busy),     32'd0);
    chk("t1_nwr",      32'(wa_q.size()), 32'd2);
    chk("t1_q_a0",     32'(wa_q[0]), 32'd0);
    chk("t1_q_d0",     wd_q[0],      32'h0050_0293);
    chk("t1_q_a1",     32'(wa_q[1]), 32'd1);
    chk("t1_q_d1",     wd_q[1],      32'h0000_0013);
    tick();
    chk("t1_waddr_hold", 32'(waddr), 32'd1);
    chk("t1_wdata_hold", wdata,      32'h0000_0013);

    // Same load with checksum byte 18 instead of D0 (flip D0^18 = C8).
    words = '{32'h0050_0293, 32'h0000_0013};
    wa_q.delete(); wd_q.delete();
    pulse_start();
    chk("t2_done_cleared", 32'(done), 32'd0);
    send_load(8'h02, words, 0, -1, 8'hC8);
    chk("t2_error", 32'(error),    32'd1);
    chk("t2_done",  32'(done),     32'd0);
    chk("t2_hold",  32'(cpu_hold), 32'd1);
    chk("t2_nwr",   32'(wa_q.size()), 32'd2);
    chk("t2_q_d1",  wd_q[1], 32'h0000_0013);

    // Length 0x41 exceeds 64 words: error right after the length byte.
    wa_q.delete(); wd_q.delete();
    pulse_start();
    chk("t3_err_cleared", 32'(error), 32'd0);
    send_byte(8'h41);
    chk("t3_error",    32'(error),    32'd1);
    chk("t3_rx_ready", 32'(rx_ready), 32'd0);
    idle(4);
    chk("t3_nwr", 32'(wa_q.size()), 32'd0);

    // Length 0 means the full 64 words.
    words.delete();
    for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_load(8'h00, words, 0, -1, 8'h00);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_nwr",  32'(wa_q.size()), 32'd64);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t4_addr", 32'(wa_q[i]), 32'(i));
      chk("t4_data", wd_q[i], words[i]);
    end

    // Unthrottled reference, then the same data with idle gaps up to 7 cycles.
    words.delete();
    for (int i = 0; i < 3; i++) words.push_back($urandom);
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_load(8'h03, words, 0, -1, 8'h00);
    chk("t5_ref_done", 32'(done), 32'd1);
    ref_q = wd_q;
    wa_q.delete(); wd_q.delete();
    pulse_start();
    gap(7);
    send_load(8'h03, words, 7, -1, 8'h00);
    chk("t5_thr_done", 32'(done), 32'd1);
    chk("t5_thr_nwr",  32'(wd_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t5_thr_vs_ref",   wd_q[i],  ref_q[i]);
      chk("t5_ref_vs_model", ref_q[i], words[i]);
    end

    // A 9-cycle gap mid-word: still loading after 7 idle cycles, error by the 8th.
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_byte(8'h03);
    send_byte(8'hAA); send_byte(8'hBB);
    idle(7);
    chk("t5_gap7_no_err", 32'(error), 32'd0);
    chk("t5_gap7_busy",   32'(busy),  32'd1);
    idle(2);
    chk("t5_tmo_error", 32'(error),    32'd1);
    chk("t5_tmo_busy",  32'(busy),     32'd0);
    chk("t5_tmo_hold",  32'(cpu_hold), 32'd1);
    chk("t5_tmo_nwr",   32'(wa_q.size()), 32'd0);

    // Reset after the sixth data byte: one word written, nothing after reset.
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    send_byte(8'h88); send_byte(8'h77);
    reset = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_we",   32'(we),   32'd0);
    chk("t6_rst_hold", 32'(cpu_hold), 32'd0);
    tick(); tick();
    reset = 1'b0;
    idle(4);
    chk("t6_nwr_after_rst", 32'(wa_q.size()), 32'd1);
    chk("t6_word0_kept",    wd_q[0], 32'h1122_3344);

    // Fresh load with a start pulse on the third data byte, which must be ignored.
    words = '{32'h1122_3344, 32'h5566_7788};
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_load(8'h02, words, 0, 2, 8'h00);
    chk("t6_done",  32'(done),  32'd1);
    chk("t6_error", 32'(error), 32'd0);
    chk("t6_nwr",   32'(wa_q.size()), 32'd2);
    chk("t6_q_d0",  wd_q[0], 32'h1122_3344);
    chk("t6_q_d1",  wd_q[1], 32'h5566_7788);
    chk("t6_q_a1",  32'(wa_q[1]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
